// File: rtl/freq_meas_pkg.sv
// Shared types and default sizing for the divided-clock measurement blocks.
package freq_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TRACK,
    LOCKED
  } fd_state_t;

  localparam int FD_CNT_W    = 16;
  localparam int FD_LOCK_CNT = 4;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a clk-synchronous strobe sampled as data.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk) begin
    // NOTE: d_q resets to 1 so an input already high at reset release is not taken as an edge.
    if (!rst) d_q <= 1'b1;
    else      d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/freq_ratio_detector.sv
// Measures period and high time of a divided clock sampled as data, and
// declares lock once successive periods agree within TOL for LOCK_CNT edges.
module freq_ratio_detector
  import freq_meas_pkg::*;
#(
  parameter int CNT_W    = FD_CNT_W,
  parameter int LOCK_CNT = FD_LOCK_CNT,
  parameter int TOL      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             stuck
);

  localparam int               MW        = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_CNT);
  localparam logic [CNT_W:0]   TOL_W     = (CNT_W + 1)'(TOL);

  logic                  rise;
  fd_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]      period_q, period_d;
  logic [CNT_W-1:0]      high_time_q, high_time_d;
  logic [MW-1:0]         match_cnt_q, match_cnt_d, match_inc;
  logic                  period_valid_q, period_valid_d;
  logic                  locked_q, locked_d;
  logic                  stuck_q, stuck_d;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]        abs_diff;
  logic                  in_tol;

  rise_detect u_rise_detect (
    .clk    (clk),
    .rst    (rst),
    .d_i    (div_in),
    .rise_o (rise)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    hi_cnt_d = hi_cnt_q;
    if (div_in && hi_cnt_q != CNT_MAX) hi_cnt_d = hi_cnt_q + CNT_W'(1);
    if (rise) begin
      cnt_d    = CNT_W'(1);
      hi_cnt_d = CNT_W'(1);
    end
  end

  // Zero-extend before subtracting so the difference never wraps.
  assign diff      = $signed({1'b0, cnt_q}) - $signed({1'b0, period_q});
  assign abs_diff  = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign in_tol    = (abs_diff <= TOL_W);
  assign match_inc = (match_cnt_q == MATCH_MAX) ? match_cnt_q : match_cnt_q + MW'(1);

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;
    match_cnt_d    = match_cnt_q;
    locked_d       = locked_q;
    stuck_d        = stuck_q;
    if (rise) begin
      stuck_d = 1'b0;
      case (state_q)
        IDLE: state_d = MEASURE;
        MEASURE: begin
          period_d       = cnt_q;
          high_time_d    = hi_cnt_q;
          period_valid_d = 1'b1;
          match_cnt_d    = '0;
          state_d        = TRACK;
        end
        TRACK, LOCKED: begin
          period_d       = cnt_q;
          high_time_d    = hi_cnt_q;
          period_valid_d = 1'b1;
          if (in_tol) begin
            match_cnt_d = match_inc;
            if (match_inc == MATCH_MAX) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_cnt_d = '0;
            locked_d    = 1'b0;
            state_d     = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (cnt_q == CNT_MAX) begin
      // No edge for a full counter span: drop lock, keep the last measurement.
      stuck_d     = 1'b1;
      locked_d    = 1'b0;
      match_cnt_d = '0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      hi_cnt_q       <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      match_cnt_q    <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      stuck_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hi_cnt_q       <= hi_cnt_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      match_cnt_q    <= match_cnt_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      stuck_q        <= stuck_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stuck        = stuck_q;

endmodule

// File: doc/freq_ratio_detector.md
# freq_ratio_detector

Receive-side companion to the frequency divider. It samples a divided clock, generated from the same `clk`, as a plain data signal. It measures the divided clock's period and high time in `clk` cycles and reports when the divide ratio has been stable long enough to be declared locked. It sits in the clock-check path of the design and lets benches and on-chip monitors confirm divider output without using the divided signal as a clock.

## Interface
- `CNT_W`, 16: width of the period and high-time counters and outputs.
- `LOCK_CNT`, 4: number of consecutive matching periods required to assert `locked` (≥1).
- `TOL`, 0: maximum absolute difference, in cycles, between successive periods that still counts as a match.

- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `div_in`  in  1  divided clock from the divider, synchronous to `clk`, treated as data.
- `period`  out  CNT_W  last measured rising-to-rising period, in cycles.
- `high_time`  out  CNT_W  cycles `div_in` was high within that period.
- `period_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `locked`  out  1  ratio stable per `LOCK_CNT` and `TOL`.
- `stuck`  out  1  no rising edge seen for 2^CNT_W−1 cycles.

## Operation
- `d_q` is the registered copy of `div_in`.
- `rise = div_in & ~d_q` is combinational, so the rising edge is detected in the first cycle `div_in` is sampled high.
- `cnt` is the period counter:
  - On `rise`: `cnt <= 1`.
  - Otherwise: `cnt <= cnt + 1`, saturating at 2^CNT_W−1.
- `hi_cnt` is the high-time counter:
  - On `rise`: `hi_cnt <= 1`.
  - Otherwise, if `div_in` is high: `hi_cnt <= hi_cnt + 1`, saturating.
  - Otherwise it holds.
- State machine states: IDLE, MEASURE, TRACK, LOCKED.
  - IDLE, on `rise`: go to MEASURE. No output update.
  - MEASURE, on `rise`: `period <= cnt`, `high_time <= hi_cnt`, pulse `period_valid`, `match_cnt <= 0`, go to TRACK.
  - TRACK/LOCKED, on `rise`: update `period`, `high_time` and `period_valid` as in MEASURE.
    - If |cnt − period| ≤ TOL: `match_cnt` increments, saturating at LOCK_CNT. When it reaches LOCK_CNT, go to LOCKED and set `locked = 1`.
    - If the difference exceeds TOL: `match_cnt <= 0`, `locked <= 0`, go to TRACK. The new period becomes the comparison reference.
  - Any state, when `cnt` reaches 2^CNT_W−1 without `rise`: `stuck <= 1`, `locked <= 0`, `match_cnt <= 0`, go to IDLE. The `period` and `high_time` values are held.
  - Any state, on `rise` while `stuck = 1`: `stuck <= 0`. This `rise` counts as the IDLE first edge.
- Difference uses CNT_W+1-bit signed arithmetic; no wrap.
- Reset (`rst` = 0 at a clock edge) has precedence over everything, including a simultaneous `rise`.
  - Reset values: state IDLE, `cnt = 0`, `hi_cnt = 0`, `match_cnt = 0`, `d_q = 1`.
  - Output reset values: `period = 0`, `high_time = 0`, `period_valid = 0`, `locked = 0`, `stuck = 0`.
  - `d_q` resets to 1 so a `div_in` already high at reset release is not treated as an edge.
- Reset mid-measurement discards all partial counts. Re-lock then requires 2 + LOCK_CNT rising edges.

## Timing
- Output latency: outputs update on the clock edge at which the first high sample of `div_in` is taken. `period_valid` is high for exactly the following cycle.
- A period of N cycles reads as `period = N`. Minimum measurable period is 2.
- `locked` first asserts on the (2 + LOCK_CNT)-th rising edge after reset with a stable ratio.
- `locked` deasserts on the same edge that captures a mismatching period.
- `stuck` asserts 2^CNT_W−1 cycles after the last rising edge.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package `freq_meas_pkg` holds:
  - the state enum `fd_state_t` (IDLE, MEASURE, TRACK, LOCKED);
  - default constants `FD_CNT_W = 16` and `FD_LOCK_CNT = 4`.
- One sub-module, `rise_detect`, contains the `d_q` register (reset to 1) and the `rise` output. The divider's own benches reuse it.
- Counters, compare logic and the state machine stay in the top module.

## Test plan
- Divide-by-4, 50% duty (`div_in` = 0,0,1,1 repeating), LOCK_CNT=4 → `period = 4` and `high_time = 2` on every `period_valid`. `locked` rises at the 6th rising edge.
- Divide-by-2 (alternating 0,1) → `period = 2`, `high_time = 1`, `period_valid` every 2 cycles.
- While locked at 4, switch to divide-by-6 → first 6-cycle period drops `locked` on that edge. `locked` re-asserts 4 edges later with `period = 6`.
- TOL=1, periods alternating 5,6,5,6 → `locked` asserts and never drops. With TOL=0 → `locked` never asserts.
- CNT_W=4, hold `div_in` low after lock → `stuck = 1` and `locked = 0` 15 cycles after the last edge. The next rising edge clears `stuck` with no `period_valid`.
- Assert `rst = 0` for one cycle mid-period while locked, with `div_in` high → all outputs 0 next cycle. No `period_valid` until the second rising edge after release.
